// File: rtl/sw_job_scheduler.sv
// Job scheduler for the Smith-Waterman core: round-robin grant between two requesters,
// buffered load, gap-free stream into the core, bounded wait for finish, tagged result.
module sw_job_scheduler #(
  parameter int SEQ_LEN = 256,
  parameter int SCORE_W = 12,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req,
  output logic [1:0]         gnt,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_s,
  input  logic [1:0]         in_t,
  output logic               core_valid,
  output logic [1:0]         core_s,
  output logic [1:0]         core_t,
  input  logic               core_finish,
  input  logic [SCORE_W-1:0] core_max,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [SCORE_W-1:0] res_max,
  output logic               res_id,
  output logic               res_err,
  output logic               busy
);

  localparam int AW = $clog2(SEQ_LEN);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [AW-1:0] LAST_IDX  = AW'(SEQ_LEN - 1);
  localparam logic [WW-1:0] LAST_WAIT = WW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]         state, state_nx;
  logic [1:0]         gnt_nx;
  logic               rr, rr_nx;
  logic               res_id_nx;
  logic [AW-1:0]      wr_cnt, wr_cnt_nx;
  logic [AW-1:0]      rd_cnt, rd_cnt_nx;
  logic [WW-1:0]      wait_cnt, wait_cnt_nx;
  logic               core_valid_nx;
  logic [1:0]         core_s_nx, core_t_nx;
  logic               res_valid_nx;
  logic [SCORE_W-1:0] res_max_nx;
  logic               res_err_nx;

  logic [3:0]         pair_buf [SEQ_LEN];
  logic [AW-1:0]      rd_addr;
  logic [3:0]         rd_data;
  logic               pick;

  assign in_ready = (state == S_LOAD);
  assign busy     = (state != S_IDLE);
  assign pick     = req[rr] ? rr : ~rr;

  // The read port runs one pair ahead so the registered core outputs carry buf[rd_cnt].
  assign rd_addr = (state == S_STREAM) ? rd_cnt + 1'b1 : '0;
  assign rd_data = pair_buf[rd_addr];

  always_ff @(posedge clk) begin
    if (state == S_LOAD && in_valid) begin
      pair_buf[wr_cnt] <= {in_s, in_t};
    end
  end

  always_comb begin
    state_nx      = state;
    gnt_nx        = gnt;
    rr_nx         = rr;
    res_id_nx     = res_id;
    wr_cnt_nx     = wr_cnt;
    rd_cnt_nx     = rd_cnt;
    wait_cnt_nx   = wait_cnt;
    core_valid_nx = core_valid;
    core_s_nx     = core_s;
    core_t_nx     = core_t;
    res_valid_nx  = res_valid;
    res_max_nx    = res_max;
    res_err_nx    = res_err;

    case (state)
      S_IDLE: begin
        if (req != 2'b00) begin
          gnt_nx    = pick ? 2'b10 : 2'b01;
          res_id_nx = pick;
          wr_cnt_nx = '0;
          state_nx  = S_LOAD;
        end
      end

      S_LOAD: begin
        if (in_valid) begin
          if (wr_cnt == LAST_IDX) begin
            wr_cnt_nx     = '0;
            rd_cnt_nx     = '0;
            core_valid_nx = 1'b1;
            core_s_nx     = rd_data[3:2];
            core_t_nx     = rd_data[1:0];
            state_nx      = S_STREAM;
          end else begin
            wr_cnt_nx = wr_cnt + 1'b1;
          end
        end
      end

      S_STREAM: begin
        core_valid_nx = 1'b0;
        if (rd_cnt == LAST_IDX) begin
          rd_cnt_nx   = '0;
          core_s_nx   = 2'b00;
          core_t_nx   = 2'b00;
          wait_cnt_nx = '0;
          state_nx    = S_WAIT;
        end else begin
          rd_cnt_nx = rd_cnt + 1'b1;
          core_s_nx = rd_data[3:2];
          core_t_nx = rd_data[1:0];
        end
      end

      // Finish is tested first so it wins over a coincident timeout.
      S_WAIT: begin
        if (core_finish) begin
          res_max_nx   = core_max;
          res_err_nx   = 1'b0;
          res_valid_nx = 1'b1;
          state_nx     = S_RESP;
        end else if (wait_cnt == LAST_WAIT) begin
          res_max_nx   = '0;
          res_err_nx   = 1'b1;
          res_valid_nx = 1'b1;
          state_nx     = S_RESP;
        end else begin
          wait_cnt_nx = wait_cnt + 1'b1;
        end
      end

      S_RESP: begin
        if (res_ready) begin
          res_valid_nx = 1'b0;
          gnt_nx       = 2'b00;
          rr_nx        = ~res_id;
          state_nx     = S_IDLE;
        end
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      gnt        <= 2'b00;
      rr         <= 1'b0;
      res_id     <= 1'b0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      wait_cnt   <= '0;
      core_valid <= 1'b0;
      core_s     <= 2'b00;
      core_t     <= 2'b00;
      res_valid  <= 1'b0;
      res_max    <= '0;
      res_err    <= 1'b0;
    end else begin
      state      <= state_nx;
      gnt        <= gnt_nx;
      rr         <= rr_nx;
      res_id     <= res_id_nx;
      wr_cnt     <= wr_cnt_nx;
      rd_cnt     <= rd_cnt_nx;
      wait_cnt   <= wait_cnt_nx;
      core_valid <= core_valid_nx;
      core_s     <= core_s_nx;
      core_t     <= core_t_nx;
      res_valid  <= res_valid_nx;
      res_max    <= res_max_nx;
      res_err    <= res_err_nx;
    end
  end

endmodule

// File: tb/tb_sw_job_scheduler.sv
// Self-checking bench for sw_job_scheduler: randomized jobs driven at the negedge and
// compared against a queue-based reference of the expected grant, stream and result.
module tb_sw_job_scheduler;

  localparam int SEQ_LEN = 256;
  localparam int SCORE_W = 12;
  localparam int TIMEOUT = 1024;

  logic               clk = 1'b0;
  logic               reset;
  logic [1:0]         req;
  logic [1:0]         gnt;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_s, in_t;
  logic               core_valid;
  logic [1:0]         core_s, core_t;
  logic               core_finish;
  logic [SCORE_W-1:0] core_max;
  logic               res_valid;
  logic               res_ready;
  logic [SCORE_W-1:0] res_max;
  logic               res_id;
  logic               res_err;
  logic               busy;

  always #5 clk = ~clk;

  sw_job_scheduler #(.SEQ_LEN(SEQ_LEN), .SCORE_W(SCORE_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt),
    .in_valid(in_valid), .in_ready(in_ready), .in_s(in_s), .in_t(in_t),
    .core_valid(core_valid), .core_s(core_s), .core_t(core_t),
    .core_finish(core_finish), .core_max(core_max),
    .res_valid(res_valid), .res_ready(res_ready), .res_max(res_max),
    .res_id(res_id), .res_err(res_err), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state: round-robin pointer and the pairs the requester handed over.
  logic               rr_m;
  logic [3:0]         exp_q[$];
  logic [3:0]         obs_q[$];
  logic [1:0]         exp_gnt;
  logic               exp_id;

  bit                 job_ok, aborted;
  logic [1:0]         obs_gnt;
  int                 grant_wait, ready_cycles, drive_cycles;
  logic               obs_ready_after;
  int                 cv_count, cv_first;
  logic [4:0]         post_stream;
  int                 wait_cycles;
  logic               obs_rv, obs_id, obs_err;
  logic [SCORE_W-1:0] obs_max;
  int                 stall_changes;
  logic [1:0]         post_gnt;
  logic               post_busy, post_rv;
  logic [23:0]        reset_snap;

  int gnt_both_cnt = 0;
  int rv_cnt = 0;
  always @(negedge clk) begin
    if (gnt === 2'b11) gnt_both_cnt++;
    if (res_valid === 1'b1) rv_cnt++;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: got time %0t expected completion before 600000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // mode: 0 = no bubbles, 1 = in_valid toggles, 2 = random bubbles.
  // fin_delay < 0 means the core never finishes; abort_at >= 0 resets mid-stream.
  task automatic run_job(input logic [1:0] r, input bit hold, input int mode,
                         input bit zero_data, input bit junk, input int fin_delay,
                         input logic [SCORE_W-1:0] fmax, input int stall, input int abort_at);
    logic [1:0] s, t;
    bit v;
    int winner;
    logic [SCORE_W+5:0] cap;
    exp_q.delete();
    obs_q.delete();
    job_ok = 1;
    aborted = 0;
    winner = r[rr_m] ? int'(rr_m) : 1 - int'(rr_m);
    exp_gnt = (winner == 1) ? 2'b10 : 2'b01;
    exp_id = (winner == 1);

    req = r;
    grant_wait = 0;
    do begin
      @(negedge clk);
      grant_wait++;
    end while (gnt === 2'b00 && grant_wait < 20);
    obs_gnt = gnt;
    if (gnt === 2'b00) begin
      job_ok = 0;
      req = 2'b00;
      return;
    end
    if (!hold) req = 2'b00;

    ready_cycles = 0;
    drive_cycles = 0;
    while (exp_q.size() < SEQ_LEN && drive_cycles < 4 * SEQ_LEN) begin
      if (in_ready === 1'b1) ready_cycles++;
      case (mode)
        0:       v = 1'b1;
        1:       v = (drive_cycles % 2 == 0);
        default: v = ($urandom_range(0, 99) >= 30);
      endcase
      s = zero_data ? 2'b00 : 2'($urandom_range(0, 3));
      t = zero_data ? 2'b00 : 2'($urandom_range(0, 3));
      in_valid = v;
      in_s = s;
      in_t = t;
      if (v) exp_q.push_back({s, t});
      drive_cycles++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    obs_ready_after = in_ready;

    cv_count = 0;
    cv_first = -1;
    for (int k = 0; k < SEQ_LEN; k++) begin
      if (k == abort_at) begin
        reset = 1'b1;
        in_valid = 1'b0;
        core_finish = 1'b0;
        @(negedge clk);
        reset_snap = {gnt, in_ready, core_valid, core_s, core_t, res_valid, res_max,
                      res_id, res_err, busy};
        reset = 1'b0;
        req = 2'b00;
        rr_m = 1'b0;
        aborted = 1;
        return;
      end
      obs_q.push_back({core_s, core_t});
      if (core_valid === 1'b1) begin
        cv_count++;
        if (cv_first < 0) cv_first = k;
      end
      in_valid = junk ? 1'($urandom) : 1'b0;
      in_s = 2'b11;
      in_t = 2'b11;
      core_finish = junk ? 1'($urandom) : 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    core_finish = 1'b0;
    post_stream = {core_valid, core_s, core_t};

    wait_cycles = 0;
    while (res_valid !== 1'b1 && wait_cycles < TIMEOUT + 50) begin
      core_finish = (wait_cycles == fin_delay);
      core_max = core_finish ? fmax : SCORE_W'($urandom);
      @(negedge clk);
      wait_cycles++;
    end
    core_finish = 1'b0;
    core_max = SCORE_W'($urandom);
    if (res_valid !== 1'b1) job_ok = 0;

    obs_rv = res_valid;
    obs_max = res_max;
    obs_id = res_id;
    obs_err = res_err;
    cap = {gnt, res_valid, res_max, res_id, res_err, busy};
    stall_changes = 0;
    for (int i = 0; i < stall; i++) begin
      res_ready = 1'b0;
      core_max = SCORE_W'($urandom);
      @(negedge clk);
      if ({gnt, res_valid, res_max, res_id, res_err, busy} !== cap) stall_changes++;
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    post_gnt = gnt;
    post_busy = busy;
    post_rv = res_valid;
    if (job_ok) rr_m = (winner == 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    rr_m = 1'b0;
    checks++; if (gnt !== 2'b00) begin failures++; $display("[TB] FAIL reset_gnt: got %b expected 00", gnt); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (core_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_core_valid: got %b expected 0", core_valid); end
    checks++; if ({core_s, core_t} !== 4'b0) begin failures++; $display("[TB] FAIL reset_core_data: got %b expected 0000", {core_s, core_t}); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_res_valid: got %b expected 0", res_valid); end
    checks++; if (res_max !== '0) begin failures++; $display("[TB] FAIL reset_res_max: got %0d expected 0", res_max); end
    checks++; if ({res_id, res_err} !== 2'b00) begin failures++; $display("[TB] FAIL reset_res_id_err: got %b expected 00", {res_id, res_err}); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if ({gnt, busy} !== 3'b000) begin failures++; $display("[TB] FAIL reset_idle_hold: got %b expected 000", {gnt, busy}); end
  endtask

  task automatic test_single_job();
    int mism;
    run_job(2'b01, 0, 0, 1, 0, 5, SCORE_W'(2048), 0, -1);
    mism = 0;
    for (int i = 0; i < SEQ_LEN; i++)
      if (i >= obs_q.size() || i >= exp_q.size() || obs_q[i] !== exp_q[i]) mism++;
    checks++; if (job_ok !== 1'b1) begin failures++; $display("[TB] FAIL single_complete: got %b expected 1", job_ok); end
    checks++; if (obs_gnt !== exp_gnt) begin failures++; $display("[TB] FAIL single_gnt: got %b expected %b", obs_gnt, exp_gnt); end
    checks++; if (grant_wait !== 1) begin failures++; $display("[TB] FAIL single_grant_latency: got %0d expected 1", grant_wait); end
    checks++; if (ready_cycles !== SEQ_LEN) begin failures++; $display("[TB] FAIL single_load_len: got %0d expected %0d", ready_cycles, SEQ_LEN); end
    checks++; if (obs_ready_after !== 1'b0) begin failures++; $display("[TB] FAIL single_ready_after: got %b expected 0", obs_ready_after); end
    checks++; if (cv_count !== 1 || cv_first !== 0) begin failures++; $display("[TB] FAIL single_core_valid: got count %0d first %0d expected 1 and 0", cv_count, cv_first); end
    checks++; if (mism !== 0) begin failures++; $display("[TB] FAIL single_stream: got %0d bad pairs expected 0", mism); end
    checks++; if (post_stream !== 5'b0) begin failures++; $display("[TB] FAIL single_post_stream: got %b expected 00000", post_stream); end
    checks++; if (wait_cycles !== 6) begin failures++; $display("[TB] FAIL single_res_latency: got %0d expected 6", wait_cycles); end
    checks++; if (obs_max !== SCORE_W'(2048)) begin failures++; $display("[TB] FAIL single_res_max: got %0d expected 2048", obs_max); end
    checks++; if ({obs_rv, obs_id, obs_err} !== {1'b1, exp_id, 1'b0}) begin failures++; $display("[TB] FAIL single_res_flags: got %b expected %b", {obs_rv, obs_id, obs_err}, {1'b1, exp_id, 1'b0}); end
    checks++; if ({post_gnt, post_busy, post_rv} !== 4'b0) begin failures++; $display("[TB] FAIL single_post_handshake: got %b expected 0000", {post_gnt, post_busy, post_rv}); end
  endtask

  task automatic test_arbitration();
    int mism, fd, both0;
    logic [SCORE_W-1:0] fm;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rr_m = 1'b0;
    both0 = gnt_both_cnt;
    for (int j = 0; j < 3; j++) begin
      fd = $urandom_range(0, 20);
      fm = SCORE_W'($urandom);
      run_job(2'b11, j < 2, 2, 0, 0, fd, fm, 0, -1);
      mism = 0;
      for (int i = 0; i < SEQ_LEN; i++)
        if (i >= obs_q.size() || i >= exp_q.size() || obs_q[i] !== exp_q[i]) mism++;
      checks++; if (obs_gnt !== exp_gnt) begin failures++; $display("[TB] FAIL arb_gnt_%0d: got %b expected %b", j, obs_gnt, exp_gnt); end
      checks++; if (obs_id !== exp_id) begin failures++; $display("[TB] FAIL arb_res_id_%0d: got %b expected %b", j, obs_id, exp_id); end
      checks++; if (grant_wait !== 1) begin failures++; $display("[TB] FAIL arb_back_to_back_%0d: got %0d cycles expected 1", j, grant_wait); end
      checks++; if (ready_cycles !== drive_cycles) begin failures++; $display("[TB] FAIL arb_load_len_%0d: got %0d expected %0d", j, ready_cycles, drive_cycles); end
      checks++; if (mism !== 0) begin failures++; $display("[TB] FAIL arb_stream_%0d: got %0d bad pairs expected 0", j, mism); end
      checks++; if (wait_cycles !== fd + 1) begin failures++; $display("[TB] FAIL arb_res_latency_%0d: got %0d expected %0d", j, wait_cycles, fd + 1); end
      checks++; if ({obs_max, obs_err} !== {fm, 1'b0}) begin failures++; $display("[TB] FAIL arb_res_%0d: got max %0d err %b expected %0d and 0", j, obs_max, obs_err, fm); end
    end
    checks++; if (gnt_both_cnt - both0 !== 0) begin failures++; $display("[TB] FAIL arb_gnt_onehot: got %0d cycles with gnt=11 expected 0", gnt_both_cnt - both0); end
  endtask

  task automatic test_load_backpressure();
    int mism;
    logic [SCORE_W-1:0] fm;
    fm = SCORE_W'($urandom_range(1, 4095));
    run_job(2'b10, 0, 1, 0, 1, 3, fm, 0, -1);
    mism = 0;
    for (int i = 0; i < SEQ_LEN; i++)
      if (i >= obs_q.size() || i >= exp_q.size() || obs_q[i] !== exp_q[i]) mism++;
    checks++; if (ready_cycles !== 2 * SEQ_LEN - 1) begin failures++; $display("[TB] FAIL bp_load_len: got %0d expected %0d", ready_cycles, 2 * SEQ_LEN - 1); end
    checks++; if (obs_ready_after !== 1'b0) begin failures++; $display("[TB] FAIL bp_ready_after: got %b expected 0", obs_ready_after); end
    checks++; if (mism !== 0) begin failures++; $display("[TB] FAIL bp_stream_order: got %0d bad pairs expected 0", mism); end
    checks++; if (cv_count !== 1 || cv_first !== 0) begin failures++; $display("[TB] FAIL bp_core_valid: got count %0d first %0d expected 1 and 0", cv_count, cv_first); end
    checks++; if (wait_cycles !== 4) begin failures++; $display("[TB] FAIL bp_res_latency: got %0d expected 4", wait_cycles); end
    checks++; if ({obs_max, obs_id, obs_err} !== {fm, exp_id, 1'b0}) begin failures++; $display("[TB] FAIL bp_res: got max %0d id %b err %b expected %0d %b 0", obs_max, obs_id, obs_err, fm, exp_id); end
  endtask

  task automatic test_result_stall();
    logic [SCORE_W-1:0] fm;
    fm = SCORE_W'($urandom_range(1, 4095));
    run_job(2'b01, 0, 2, 0, 0, 2, fm, 10, -1);
    checks++; if (obs_rv !== 1'b1) begin failures++; $display("[TB] FAIL stall_res_valid: got %b expected 1", obs_rv); end
    checks++; if (stall_changes !== 0) begin failures++; $display("[TB] FAIL stall_stable: got %0d changed cycles expected 0", stall_changes); end
    checks++; if ({obs_max, obs_id} !== {fm, exp_id}) begin failures++; $display("[TB] FAIL stall_res: got max %0d id %b expected %0d %b", obs_max, obs_id, fm, exp_id); end
    checks++; if ({post_gnt, post_busy, post_rv} !== 4'b0) begin failures++; $display("[TB] FAIL stall_post_handshake: got %b expected 0000", {post_gnt, post_busy, post_rv}); end
  endtask

  task automatic test_timeout();
    logic [SCORE_W-1:0] fm;
    run_job(2'b01, 0, 0, 0, 0, -1, SCORE_W'(0), 0, -1);
    checks++; if (wait_cycles !== TIMEOUT) begin failures++; $display("[TB] FAIL timeout_len: got %0d expected %0d", wait_cycles, TIMEOUT); end
    checks++; if ({obs_rv, obs_err} !== 2'b11) begin failures++; $display("[TB] FAIL timeout_err: got valid/err %b expected 11", {obs_rv, obs_err}); end
    checks++; if (obs_max !== '0) begin failures++; $display("[TB] FAIL timeout_max: got %0d expected 0", obs_max); end
    fm = SCORE_W'($urandom_range(1, 4095));
    run_job(2'b01, 0, 0, 0, 0, TIMEOUT - 1, fm, 0, -1);
    checks++; if (wait_cycles !== TIMEOUT) begin failures++; $display("[TB] FAIL tie_len: got %0d expected %0d", wait_cycles, TIMEOUT); end
    checks++; if ({obs_max, obs_err} !== {fm, 1'b0}) begin failures++; $display("[TB] FAIL tie_finish_wins: got max %0d err %b expected %0d 0", obs_max, obs_err, fm); end
  endtask

  task automatic test_reset_mid_stream();
    int mism, rv0;
    logic [SCORE_W-1:0] fm;
    run_job(2'b01, 0, 0, 0, 0, 5, SCORE_W'(77), 0, 100);
    checks++; if (aborted !== 1'b1) begin failures++; $display("[TB] FAIL rst_reached_stream: got %b expected 1", aborted); end
    checks++; if (reset_snap !== 24'b0) begin failures++; $display("[TB] FAIL rst_outputs: got %h expected 000000", reset_snap); end
    rv0 = rv_cnt;
    repeat (20) @(negedge clk);
    checks++; if (rv_cnt - rv0 !== 0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_no_result: got %0d res_valid cycles busy %b expected 0 and 0", rv_cnt - rv0, busy); end
    fm = SCORE_W'($urandom_range(1, 4095));
    run_job(2'b11, 0, 2, 0, 0, 4, fm, 0, -1);
    mism = 0;
    for (int i = 0; i < SEQ_LEN; i++)
      if (i >= obs_q.size() || i >= exp_q.size() || obs_q[i] !== exp_q[i]) mism++;
    checks++; if (obs_gnt !== exp_gnt) begin failures++; $display("[TB] FAIL rst_rr_cleared: got gnt %b expected %b", obs_gnt, exp_gnt); end
    checks++; if (mism !== 0) begin failures++; $display("[TB] FAIL rst_next_stream: got %0d bad pairs expected 0", mism); end
    checks++; if ({obs_rv, obs_max, obs_id, obs_err} !== {1'b1, fm, exp_id, 1'b0}) begin failures++; $display("[TB] FAIL rst_next_result: got max %0d id %b err %b expected %0d %b 0", obs_max, obs_id, obs_err, fm, exp_id); end
  endtask

  initial begin
    reset = 1'b1;
    req = 2'b00;
    in_valid = 1'b0;
    in_s = 2'b00;
    in_t = 2'b00;
    core_finish = 1'b0;
    core_max = '0;
    res_ready = 1'b0;
    rr_m = 1'b0;
    test_reset();
    test_single_job();
    test_arbitration();
    test_load_backpressure();
    test_result_stall();
    test_timeout();
    test_reset_mid_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
